// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - Execute-stage multiply/divide unit with HI/LO registers and Start/Busy handshake
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  output logic        Start,
  output logic        Busy,
  input  logic        RdHi,
  output logic [31:0] MDUOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt_q;

  logic          is_arith;
  logic [31:0]   res_hi_d, res_lo_d;
  logic          res_wr_d;
  logic [63:0]   prod_s, prod_u;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag;

  assign is_arith = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                    (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign Start    = is_arith && (state_q == S_IDLE);
  assign Busy     = (state_q == S_RUN);
  assign MDUOut   = RdHi ? hi_q : lo_q;

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow traps.
  assign a_neg  = a_q[31];
  assign b_neg  = b_q[31];
  assign a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
  assign q_mag  = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
  assign r_mag  = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Result of the latched operation, committed to HI/LO on the last Busy cycle.
  always_comb begin
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    res_wr_d = 1'b0;
    case (op_q)
      OP_MULT: begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
        res_wr_d = 1'b1;
      end
      OP_MULTU: begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
        res_wr_d = 1'b1;
      end
      OP_DIV: begin
        if (b_q != 32'd0) begin
          res_lo_d = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
          res_hi_d = a_neg ? (~r_mag + 32'd1) : r_mag;
          res_wr_d = 1'b1;
        end
      end
      OP_DIVU: begin
        if (b_q != 32'd0) begin
          res_lo_d = a_q / b_q;
          res_hi_d = a_q % b_q;
          res_wr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control FSM: IDLE accepts new ops and mthi/mtlo; RUN counts down and commits at count 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_arith) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= MDUOp;
            cnt_q   <= ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
            state_q <= S_RUN;
          end else if (MDUOp == OP_MTHI) begin
            hi_q <= A;
          end else if (MDUOp == OP_MTLO) begin
            lo_q <= A;
          end
        end
        S_RUN: begin
          if (cnt_q == CNT_ONE) begin
            if (res_wr_d) begin
              hi_q <= res_hi_d;
              lo_q <= res_lo_d;
            end
            cnt_q   <= '0;
            op_q    <= 3'd0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the Execute stage of the P6 five-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi, mtlo and supplies HI/LO to mfhi/mflo.
- Result is forwarded into the E/M pipeline register; the M-stage controller then treats mfhi/mflo as register-writing loads with Tnew 0.
- Exports Start/Busy so the D-stage stall logic can hold any multiply/divide-class instruction while a multi-cycle operation is in flight.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu.
- DIV_CYCLES, 10, number of Busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  32  forwarded rs value in E.
- B  input  32  forwarded rt value in E.
- MDUOp  input  3  operation code:
  - 000 none
  - 001 mult
  - 010 multu
  - 011 div
  - 100 divu
  - 101 mthi
  - 110 mtlo
  - 111 reserved, treated as none.
- Start  output  1  combinational; high when MDUOp is in 001..100 and Busy is 0.
- Busy  output  1  registered; high while an operation is in progress.
- RdHi  input  1  1 = mfhi, 0 = mflo.
- MDUOut  output  32  combinational; RdHi ? HI : LO.

Behaviour:
- Reset, synchronous, highest priority:
  - HI, LO, operand latches, counter and result latches are cleared to 0; Busy=0.
  - Reset mid-operation aborts it with no HI/LO update.
- States:
  - IDLE (Busy=0): cycle counter is 0.
  - RUN (Busy=1): counter counts down to 1.
- IDLE, Start at edge t:
  - Latch A, B and the op.
  - Compute the result into internal registers: a behavioural 64-bit product or quotient/remainder is acceptable.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter is 1, commit the result to HI/LO, set Busy=0 and return to IDLE.
  - Busy is therefore high for exactly N cycles following the Start cycle.
- Timing example, mult with Start in cycle t:
  - Busy is high in cycles t+1..t+5.
  - HI/LO hold the new values from cycle t+6.
  - An mfhi entering E in cycle t+6 reads the new HI.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: {HI,LO} = unsigned product.
  - div: LO = A/B, HI = A%B, signed. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Division by zero (B==0, div or divu): Busy runs the full DIV_CYCLES; HI and LO are left unchanged at commit.
  - Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0; no exception.
- mthi/mtlo:
  - In IDLE, write HI=A or LO=A at the edge.
  - Single cycle; Busy stays 0; Start stays 0.
- Commands while Busy:
  - mult/div/mthi/mtlo presented while Busy=1 are ignored and have no effect; Start stays 0.
  - The D-stage stall logic guarantees that this does not happen in normal operation.
- Reading HI/LO:
  - MDUOut always reflects the current HI/LO registers, including during RUN, where it shows the old values.
  - The stall unit blocks mfhi/mflo while Start or Busy is high.
- No pipeline-flush input: an operation, once started, completes.

Test Plan:
- Reset, then mult with A=0xFFFFFFFF (-1), B=2:
  - Start=1 in that cycle; Busy high for exactly 5 cycles.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MDUOut shows the old LO=0 while Busy.
- multu with A=0xFFFFFFFF, B=2:
  - After 5 Busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div with A=-7 (0xFFFFFFF9), B=2:
  - Busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu with A=0xFFFFFFF9, B=2:
  - LO=0x7FFFFFFC, HI=0x00000001.
- div with B=0, after mthi 0x1234 and mtlo 0x5678:
  - Busy runs 10 cycles; HI=0x1234 and LO=0x5678 remain unchanged.
  - Each mthi/mtlo takes effect the next cycle with Busy=0.
- Mid-operation commands and reset:
  - Start a div; in the 3rd Busy cycle present mtlo A=0xAAAA → ignored, Start stays 0.
  - Assert reset in the 5th Busy cycle → next cycle Busy=0, HI=LO=0, no later commit.
